// File: rtl/major_state_seq_pkg.sv
// Shared constants for the PDP-8e major-state sequencer: state codes,
// opcode values and the group-2 HLT match pattern.
package major_state_seq_pkg;

   typedef enum logic [4:0] {
      F0 = 5'd0,  F1 = 5'd1,  F2 = 5'd2,  F3 = 5'd3,
      D0 = 5'd4,  D1 = 5'd5,  D2 = 5'd6,  D3 = 5'd7,
      E0 = 5'd8,  E1 = 5'd9,  E2 = 5'd10, E3 = 5'd11,
      H0 = 5'd12, H1 = 5'd13, H2 = 5'd14, H3 = 5'd15
   } state_e;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_TAD = 3'd1;
   localparam logic [2:0] OP_ISZ = 3'd2;
   localparam logic [2:0] OP_DCA = 3'd3;
   localparam logic [2:0] OP_JMS = 3'd4;
   localparam logic [2:0] OP_JMP = 3'd5;
   localparam logic [2:0] OP_IOT = 3'd6;
   localparam logic [2:0] OP_OPR = 3'd7;

   // HLT: 1111 xxxx xx10 (group-2 operate, bit 10 set, bit 11 clear)
   localparam logic [0:11] HLT_MASK = 12'o7403;
   localparam logic [0:11] HLT_VAL  = 12'o7402;

   // Interrupt entry is a forced JMS 0
   localparam logic [0:11] INT_INSTR = 12'o4000;

   function automatic logic hlt_match(input logic [0:11] instr);
      return (instr & HLT_MASK) == HLT_VAL;
   endfunction

endpackage

// File: rtl/major_state_seq_if.sv
// Front-panel / memory / datapath signal bundle for major_state_seq.
// Optional macro INTERRUPT_EN adds int_req, ion and int_ack.
interface major_state_seq_if;
   logic [0:11] mdout;
   logic        cont;
   logic        clear_sw;
   logic        halt_sw;
   logic        sing_step;
   logic        UF;
   logic [4:0]  state;
   logic [0:11] instruction;
   logic        clear;
   logic        run;
`ifdef INTERRUPT_EN
   logic        int_req;
   logic        ion;
   logic        int_ack;
`endif

`ifdef INTERRUPT_EN
   modport master (output mdout, cont, clear_sw, halt_sw, sing_step, UF, int_req, ion,
                   input  state, instruction, clear, run, int_ack);
   modport slave  (input  mdout, cont, clear_sw, halt_sw, sing_step, UF, int_req, ion,
                   output state, instruction, clear, run, int_ack);
`else
   modport master (output mdout, cont, clear_sw, halt_sw, sing_step, UF,
                   input  state, instruction, clear, run);
   modport slave  (input  mdout, cont, clear_sw, halt_sw, sing_step, UF,
                   output state, instruction, clear, run);
`endif
endinterface

// File: rtl/major_state_seq_instr_decode.sv
// Combinational opcode classification used by the major-state next-state logic.
import major_state_seq_pkg::*;

module major_state_seq_instr_decode (
   input  logic [0:11] instruction_i,
   input  logic        uf_i,
   output logic        is_mem_ref_o,
   output logic        is_indirect_o,
   output logic        is_jmp_o,
   output logic        is_hlt_o
);
   logic [2:0] op;

   // Memory-reference ops are 0..5; HLT only halts outside user mode
   always_comb begin
      op            = instruction_i[0:2];
      is_mem_ref_o  = (op != OP_IOT) && (op != OP_OPR);
      is_indirect_o = is_mem_ref_o && instruction_i[3];
      is_jmp_o      = (op == OP_JMP);
      is_hlt_o      = hlt_match(instruction_i) && !uf_i;
   end
endmodule

// File: rtl/major_state_seq.sv
// PDP-8e major-state sequencer: F/D/E/H state codes, instruction register,
// panel handling and clear strobe. Optional macro INTERRUPT_EN.
import major_state_seq_pkg::*;

module major_state_seq (
   input logic              clk,
   input logic              reset,
   major_state_seq_if.slave bus
);
   state_e      state_q, state_d;
   logic [0:11] instr_q, instr_d;
   logic        clear_q, run_q;
   logic        load_ir, boundary, stop_req;
   logic        is_mem_ref, is_indirect, is_jmp, is_hlt;
`ifdef INTERRUPT_EN
   logic        int_ack_q, int_go;
`endif

   major_state_seq_instr_decode u_dec (
      .instruction_i (instr_q),
      .uf_i          (bus.UF),
      .is_mem_ref_o  (is_mem_ref),
      .is_indirect_o (is_indirect),
      .is_jmp_o      (is_jmp),
      .is_hlt_o      (is_hlt)
   );

   // Next-state, IR load and boundary resolution
   always_comb begin
      state_d  = H0;
      load_ir  = 1'b0;
      boundary = 1'b0;
      stop_req = bus.halt_sw || bus.sing_step;
      case (state_q)
         F0: begin state_d = F1; load_ir = 1'b1; end
         F1: state_d = F2;
         F2: state_d = F3;
         F3: begin
            if (is_indirect)                  state_d = D0;
            else if (is_mem_ref && !is_jmp)   state_d = E0;
            else if (is_hlt)                  state_d = H0;
            else                              boundary = 1'b1;
         end
         D0: state_d = D1;
         D1: state_d = D2;
         D2: state_d = D3;
         D3: begin
            if (is_jmp) boundary = 1'b1;
            else        state_d = E0;
         end
         E0: state_d = E1;
         E1: state_d = E2;
         E2: state_d = E3;
         E3: boundary = 1'b1;
         H0: begin
            if (bus.clear_sw)  state_d = H1;
            else if (bus.cont) state_d = F0;
            else               state_d = H0;
         end
         H1: state_d = H2;
         H2: state_d = H3;
         H3: state_d = H0;
         default: state_d = H0;
      endcase
      if (boundary) state_d = stop_req ? H0 : F0;

      instr_d = instr_q;
`ifdef INTERRUPT_EN
      int_go = boundary && !stop_req && bus.int_req && bus.ion;
      if (load_ir) instr_d = int_ack_q ? INT_INSTR : bus.mdout;
`else
      if (load_ir) instr_d = bus.mdout;
`endif
   end

   // State, IR and registered run/clear outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= H0;
         instr_q <= '0;
         clear_q <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         clear_q <= (state_d == H1);
         run_q   <= !(state_d inside {H0, H1, H2, H3});
      end
   end

`ifdef INTERRUPT_EN
   // int_ack is high exactly for the F0 cycle entered on an interrupt
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) int_ack_q <= 1'b0;
      else        int_ack_q <= int_go;
   end
   assign bus.int_ack = int_ack_q;
`endif

   assign bus.state       = state_q;
   assign bus.instruction = instr_q;
   assign bus.clear       = clear_q;
   assign bus.run         = run_q;
endmodule

// File: doc/major_state_seq.md
Name: major_state_seq

Overview:
- Major-state sequencer for the PDP-8e core.
- Generates the 5-bit `state` code (F0–F3 fetch, D0–D3 defer, E0–E3 execute, H0–H3 halt/panel) consumed by the accumulator, memory and IOT stages.
- Holds the instruction register, loaded from memory data during fetch.
- Decides fetch→defer→execute→halt transitions from the opcode and the front-panel controls.

Parameters:
- None. State codes and opcode constants come from the shared package.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- mdout  input  [0:11]  memory read data, valid during F0 and D0
- cont  input  1  panel CONT pulse, one clk wide
- clear_sw  input  1  panel CLEAR pulse, one clk wide
- halt_sw  input  1  panel HALT switch, level
- sing_step  input  1  panel SING STEP switch, level
- UF  input  1  user-mode flag
- state  output  [4:0]  current major state code
- instruction  output  [0:11]  instruction register
- clear  output  1  system clear strobe to the datapath
- run  output  1  high while not in H0–H3

Behaviour:
- Reset (async, active-low): state=H0, instruction=0, clear=0, run=0. Asserting reset mid-instruction abandons the instruction; the sequencer restarts in H0.
- Every sub-state lasts exactly one clk. Sequences always run X0→X1→X2→X3; decisions are taken only at X3 or in H0.
- instruction is loaded from mdout on the clk edge leaving F0 and is stable from F1 through E3.
- At F3 exit, let op=instruction[0:2], ind=instruction[3]:
  - op 0–5 with ind=1 → D0.
  - op 0–4 with ind=0 → E0.
  - op 5 (JMP) with ind=0 → boundary.
  - op 6 (IOT) or op 7 (operate) → boundary, except HLT (group-2 pattern 1111???????? with bit 10 =1, bit 11 =0) with UF=0 → H0. HLT with UF=1 is a boundary (no halt).
- At D3 exit: JMP → boundary; otherwise → E0.
- At E3 exit → boundary.
- Boundary resolution, in priority order:
  - halt_sw=1 or sing_step=1 → H0.
  - otherwise → F0.
- H0 behaviour:
  - clear_sw → H1, with clear=1 for the H1 cycle only; then H2, H3, back to H0.
  - cont (no clear_sw) → F0. If halt_sw or sing_step is still high, exactly one instruction executes before returning to H0.
  - clear_sw and cont in the same cycle: clear_sw wins; cont is dropped.
  - cont or clear_sw outside H0 is ignored and not queued.
- run=0 in H0–H3, run=1 elsewhere; registered with state.
- clear is asserted only in H1. It never coincides with F/D/E states.
- State encoding (package): F0–F3=0–3, D0–D3=4–7, E0–E3=8–11, H0–H3=12–15. Codes 16–31 are illegal and recover to H0 on the next clk.

Optional Feature:
- Macro: INTERRUPT_EN.
- When defined, adds inputs int_req and ion and output int_ack.
- At a boundary that would go to F0, if int_req & ion:
  - go to F0 anyway;
  - on the F0 exit edge, instruction loads 12'o4000 (JMS 0) instead of mdout;
  - int_ack pulses high for the F0 cycle.
- Halt and sing_step take priority over an interrupt.
- When not defined: no extra ports; behaviour exactly as above.

Decomposition:
- Shared package holds:
  - state code constants F0–H3;
  - opcode constants AND, TAD, ISZ, DCA, JMS, JMP, IOT, OPR;
  - the HLT match pattern.
- One natural sub-module, instr_decode: combinational. Takes instruction and UF, produces is_mem_ref, is_indirect, is_jmp, is_hlt for the next-state logic.

Test Plan:
- Reset low then high → state=12 (H0), run=0, instruction=0; pulse cont → state 0,1,2,3 on successive clks.
- Run with mdout=12'o1234 (TAD direct) → F0–F3, E0–E3, then F0; instruction=12'o1234 from F1.
- mdout=12'o5600 (JMP indirect) → F0–F3, D0–D3, then F0, with no E states.
- mdout=12'o7402 (HLT): UF=0 → H0 after F3, run drops. UF=1 → F0 after F3.
- In H0, assert clear_sw and cont in the same cycle → H1 with clear=1 for one clk, H2, H3, H0; no F0 entered.
- sing_step=1, pulse cont with mdout=12'o7000 → F0–F3 then H0; a second cont repeats exactly one instruction.
